// File: rtl/tmds_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder_if
//  Description : TMDS decoder link bundle: the parallel 10-bit word from the
//                deserializer, the bitslip request back to it, and the decoded
//                pixel/control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tmds_decoder_if;
  logic [9:0] tmds_din;
  logic       bitslip;
  logic       aligned;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] dout;

  // Deserializer / pixel sink side
  modport master (
    output tmds_din,
    input  bitslip, aligned, de, c0, c1, dout
  );

  // Decoder side
  modport slave (
    input  tmds_din,
    output bitslip, aligned, de, c0, c1, dout
  );
endinterface
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : TMDS channel decoder with control-token word alignment.
//                Two register stages (input capture, decode). A three-state
//                FSM hunts for a run of control tokens, requests a bitslip
//                when none is found in time, and drops lock after a long
//                stretch without any control token.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
  parameter int CTRL_LOCK      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4095,
  parameter int SLIP_WAIT      = 16
) (
  input  logic          pclk,
  input  logic          rst_n,
  tmds_decoder_if.slave bus
);

  localparam logic [9:0]  c_TOK_00         = 10'b1101010100;
  localparam logic [9:0]  c_TOK_01         = 10'b0010101011;
  localparam logic [9:0]  c_TOK_10         = 10'b0101010100;
  localparam logic [9:0]  c_TOK_11         = 10'b1010101011;
  localparam logic [11:0] c_CTRL_LOCK      = 12'(CTRL_LOCK);
  localparam logic [11:0] c_SEARCH_TIMEOUT = 12'(SEARCH_TIMEOUT);
  localparam logic [11:0] c_LOSS_TIMEOUT   = 12'(LOSS_TIMEOUT);
  localparam logic [11:0] c_SLIP_WAIT      = 12'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t      r_state, w_state_next;
  logic [9:0]  r_din;
  logic [11:0] r_run, w_run_next;
  logic [11:0] r_search, w_search_next;
  logic [11:0] r_loss, w_loss_next;
  logic [11:0] r_wait, w_wait_next;
  logic [11:0] w_run_inc, w_search_inc, w_loss_inc, w_wait_inc;
  logic        w_bitslip_next;
  logic        w_is_token;
  logic [1:0]  w_tok_c;
  logic [7:0]  w_d;
  logic [7:0]  w_dec;
  logic        r_bitslip, r_aligned, r_de, r_c0, r_c1;
  logic [7:0]  r_dout;

  // Classify the captured word as one of the four control tokens or data
  always_comb begin
    w_is_token = 1'b1;
    w_tok_c    = 2'b00;
    case (r_din)
      c_TOK_00: w_tok_c = 2'b00;
      c_TOK_01: w_tok_c = 2'b01;
      c_TOK_10: w_tok_c = 2'b10;
      c_TOK_11: w_tok_c = 2'b11;
      default:  w_is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    w_d      = r_din[9] ? ~r_din[7:0] : r_din[7:0];
    w_dec    = 8'h00;
    w_dec[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = r_din[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  // Alignment FSM: next state, counter updates and slip request
  always_comb begin
    w_state_next   = r_state;
    w_run_next     = r_run;
    w_search_next  = r_search;
    w_loss_next    = r_loss;
    w_wait_next    = r_wait;
    w_bitslip_next = 1'b0;
    w_run_inc      = w_is_token ? sat_inc(r_run) : 12'd0;
    w_search_inc   = sat_inc(r_search);
    w_loss_inc     = sat_inc(r_loss);
    w_wait_inc     = sat_inc(r_wait);
    case (r_state)
      ST_SEARCH: begin
        // A completed token run wins over a timeout landing on the same word
        if (w_is_token && (w_run_inc >= c_CTRL_LOCK)) begin
          w_state_next  = ST_LOCKED;
          w_run_next    = 12'd0;
          w_search_next = 12'd0;
          w_loss_next   = 12'd0;
        end else if (w_search_inc >= c_SEARCH_TIMEOUT) begin
          w_state_next   = ST_SLIP;
          w_bitslip_next = 1'b1;
          w_run_next     = 12'd0;
          w_search_next  = 12'd0;
          w_wait_next    = 12'd0;
        end else begin
          w_run_next    = w_run_inc;
          w_search_next = w_search_inc;
        end
      end
      ST_SLIP: begin
        // Words are ignored while the deserializer settles on the new boundary
        if (w_wait_inc >= c_SLIP_WAIT) begin
          w_state_next  = ST_SEARCH;
          w_wait_next   = 12'd0;
          w_run_next    = 12'd0;
          w_search_next = 12'd0;
        end else begin
          w_wait_next = w_wait_inc;
        end
      end
      ST_LOCKED: begin
        if (w_is_token) begin
          w_loss_next = 12'd0;
        end else if (w_loss_inc >= c_LOSS_TIMEOUT) begin
          // Lock dropped without a slip: the boundary may still be correct
          w_state_next  = ST_SEARCH;
          w_loss_next   = 12'd0;
          w_run_next    = 12'd0;
          w_search_next = 12'd0;
        end else begin
          w_loss_next = w_loss_inc;
        end
      end
      default: begin
        w_state_next  = ST_SEARCH;
        w_run_next    = 12'd0;
        w_search_next = 12'd0;
        w_loss_next   = 12'd0;
        w_wait_next   = 12'd0;
      end
    endcase
  end

  // State, counters, slip pulse and the input capture stage
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SEARCH;
      r_din     <= 10'd0;
      r_run     <= 12'd0;
      r_search  <= 12'd0;
      r_loss    <= 12'd0;
      r_wait    <= 12'd0;
      r_bitslip <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_din     <= bus.tmds_din;
      r_run     <= w_run_next;
      r_search  <= w_search_next;
      r_loss    <= w_loss_next;
      r_wait    <= w_wait_next;
      r_bitslip <= w_bitslip_next;
    end
  end

  // Decode stage: aligned and de both derive from the current state here
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_aligned <= 1'b0;
      r_de      <= 1'b0;
      r_dout    <= 8'h00;
      r_c0      <= 1'b0;
      r_c1      <= 1'b0;
    end else begin
      r_aligned <= (r_state == ST_LOCKED);
      if (w_is_token) begin
        r_de   <= 1'b0;
        r_dout <= 8'h00;
        r_c1   <= w_tok_c[1];
        r_c0   <= w_tok_c[0];
      end else if (r_state == ST_LOCKED) begin
        r_de   <= 1'b1;
        r_dout <= w_dec;
      end else begin
        r_de   <= 1'b0;
        r_dout <= 8'h00;
      end
    end
  end

  assign bus.bitslip = r_bitslip;
  assign bus.aligned = r_aligned;
  assign bus.de      = r_de;
  assign bus.dout    = r_dout;
  assign bus.c0      = r_c0;
  assign bus.c1      = r_c1;

endmodule
`default_nettype wire
